// File: rtl/uart_baud_gen.sv
// UART baud timing generator: oversample tick, mid-bit and bit-end pulses from one divider chain.
// Build option UART_BAUD_FRAC_EN adds 4 fractional divisor bits with a carry accumulator.
module uart_baud_gen #(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned BAUD0        = 9600,
    parameter int unsigned BAUD1        = 19200,
    parameter int unsigned BAUD2        = 38400,
    parameter int unsigned BAUD3        = 115200,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned SAMPLE_POINT = 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [1:0]                    baud_sel,
    input  logic                          sync_restart,
    output logic                          os_tick,
    output logic                          bit_mid,
    output logic                          bit_end,
    output logic [$clog2(OVERSAMPLE)-1:0] phase
);

    localparam int unsigned PW = $clog2(OVERSAMPLE);
`ifdef UART_BAUD_FRAC_EN
    localparam int unsigned FB = 4;
`else
    localparam int unsigned FB = 0;
`endif

    // Rounded divisor scaled by 2^FB; the integer part sits above the FB fraction bits.
    function automatic longint unsigned scaled_div(input longint unsigned baud);
        longint unsigned den;
        den = baud * OVERSAMPLE;
        return ((64'(CLK_HZ) << FB) + den / 2) / den;
    endfunction

    function automatic bit div_ok(input longint unsigned fd);
        return ((fd >> FB) >= 2) && ((fd >> FB) < (64'd1 << CNT_W));
    endfunction

    localparam longint unsigned FD0 = scaled_div(BAUD0);
    localparam longint unsigned FD1 = scaled_div(BAUD1);
    localparam longint unsigned FD2 = scaled_div(BAUD2);
    localparam longint unsigned FD3 = scaled_div(BAUD3);

    if (!(div_ok(FD0) && div_ok(FD1) && div_ok(FD2) && div_ok(FD3))) begin : g_div_range
        $error("uart_baud_gen: a baud divisor is below 2 or does not fit CNT_W");
    end
    if (OVERSAMPLE < 4 || OVERSAMPLE > 64 || SAMPLE_POINT < 1 || SAMPLE_POINT > OVERSAMPLE) begin : g_os_range
        $error("uart_baud_gen: OVERSAMPLE or SAMPLE_POINT out of range");
    end

    localparam logic [CNT_W-1:0] INT0 = CNT_W'(FD0 >> FB);
    localparam logic [CNT_W-1:0] INT1 = CNT_W'(FD1 >> FB);
    localparam logic [CNT_W-1:0] INT2 = CNT_W'(FD2 >> FB);
    localparam logic [CNT_W-1:0] INT3 = CNT_W'(FD3 >> FB);
    localparam logic [PW-1:0]    PH_MID  = PW'(SAMPLE_POINT - 1);
    localparam logic [PW-1:0]    PH_LAST = PW'(OVERSAMPLE - 1);

    logic [CNT_W-1:0] sel_int;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_eff;
    logic [CNT_W-1:0] last_cnt;
    logic [CNT_W-1:0] count;
    logic             div_valid;
    logic             wrap;

    always_comb begin
        sel_int = INT0;
        case (baud_sel)
            2'd0:    sel_int = INT0;
            2'd1:    sel_int = INT1;
            2'd2:    sel_int = INT2;
            default: sel_int = INT3;
        endcase
    end

`ifdef UART_BAUD_FRAC_EN
    localparam logic [3:0] FRC0 = 4'(FD0);
    localparam logic [3:0] FRC1 = 4'(FD1);
    localparam logic [3:0] FRC2 = 4'(FD2);
    localparam logic [3:0] FRC3 = 4'(FD3);

    logic [3:0] sel_frac;
    logic [3:0] acc;
    logic       extra;

    always_comb begin
        sel_frac = FRC0;
        case (baud_sel)
            2'd0:    sel_frac = FRC0;
            2'd1:    sel_frac = FRC1;
            2'd2:    sel_frac = FRC2;
            default: sel_frac = FRC3;
        endcase
    end

    // The carry from this wrap lengthens the next oversample period by one clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            extra <= 1'b0;
        end else if (!enable || sync_restart) begin
            acc   <= '0;
            extra <= 1'b0;
        end else if (wrap) begin
            {extra, acc} <= {1'b0, acc} + {1'b0, sel_frac};
        end
    end
`endif

    // Before the first enabled cycle after reset no divisor has been latched yet.
    always_comb begin
        div_eff = div_valid ? div_act : sel_int;
`ifdef UART_BAUD_FRAC_EN
        last_cnt = div_eff - CNT_W'(1) + CNT_W'(extra);
`else
        last_cnt = div_eff - CNT_W'(1);
`endif
        wrap = (count == last_cnt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            div_act   <= '0;
            div_valid <= 1'b0;
            phase     <= '0;
            os_tick   <= 1'b0;
            bit_mid   <= 1'b0;
            bit_end   <= 1'b0;
        end else if (!enable || sync_restart) begin
            count     <= '0;
            div_act   <= sel_int;
            div_valid <= 1'b1;
            phase     <= '0;
            os_tick   <= 1'b0;
            bit_mid   <= 1'b0;
            bit_end   <= 1'b0;
        end else if (wrap) begin
            count     <= '0;
            div_act   <= sel_int;
            div_valid <= 1'b1;
            phase     <= (phase == PH_LAST) ? '0 : phase + PW'(1);
            os_tick   <= 1'b1;
            bit_mid   <= (phase == PH_MID);
            bit_end   <= (phase == PH_LAST);
        end else begin
            count     <= count + CNT_W'(1);
            div_act   <= div_eff;
            div_valid <= 1'b1;
            os_tick   <= 1'b0;
            bit_mid   <= 1'b0;
            bit_end   <= 1'b0;
        end
    end

endmodule
